// File: rtl/biquad8_ctrl_pkg.sv
// Shared constants for the biquad8 coefficient loader: FSM encodings,
// wrapper register offsets and field widths.
package biquad8_ctrl_pkg;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_WR    = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd2;
  localparam logic [ST_W-1:0] ST_UPD   = 3'd3;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

  // Byte offsets of the registers inside one 128-byte wrapper window.
  localparam logic [6:0] REG_UPDATE  = 7'h00;
  localparam logic [6:0] REG_FIR     = 7'h04;
  localparam logic [6:0] REG_IIR     = 7'h08;
  localparam logic [6:0] REG_F_CHAIN = 7'h10;
  localparam logic [6:0] REG_G_CHAIN = 7'h14;
  localparam logic [6:0] REG_F_XLINK = 7'h18;
  localparam logic [6:0] REG_G_XLINK = 7'h1C;

  localparam int unsigned DEF_TIMEOUT = 1023;
  localparam int unsigned WORD_W      = 5;
  localparam int unsigned COEF_W      = 18;
  localparam int unsigned WB_DAT_W    = 32;
  localparam int unsigned WR_CNT_W    = 16;

endpackage

// File: rtl/biquad8_coeff_loader_wb_write_timer.sv
// Ack timeout down-counter: loaded when a write starts, expires after
// TIMEOUT running cycles without a response.
module wb_write_timer
  import biquad8_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic load,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Reload on write entry, count down while the write is outstanding.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT);
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_c = run && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Wishbone master turning coefficient beats into writes to a bank of
// biquad8 wrappers, with optional end-of-packet update write.
module biquad8_coeff_loader
  import biquad8_ctrl_pkg::*;
#(
  parameter int unsigned NTARGET     = 16,
  parameter int unsigned TGTBITS     = 4,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned AUTO_UPDATE = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [TGTBITS-1:0]  s_target_i,
  input  logic [4:0]          s_addr_i,
  input  logic [17:0]         s_data_i,
  input  logic                s_last_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [TGTBITS+6:0]  wb_adr_o,
  output logic [31:0]         wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [TGTBITS+6:0]  err_adr_o,
  input  logic                err_clr_i,
  output logic [15:0]         wr_count_o
);

  localparam int unsigned ADR_W = 7 + TGTBITS;

  if (NTARGET > (1 << TGTBITS)) begin : g_bad_cfg
    $error("biquad8_coeff_loader: TGTBITS too small for NTARGET");
  end

  logic [ST_W-1:0]     state_q, state_d;
  logic [TGTBITS-1:0]  tgt_q, tgt_d;
  logic                last_q, last_d;
  logic                cyc_d, ready_d, busy_d, done_d, err_d;
  logic [ADR_W-1:0]    adr_d, err_adr_d;
  logic [WB_DAT_W-1:0] dat_d;
  logic [WR_CNT_W-1:0] cnt_d;
  logic                hs_c, active_c, ack_ok_c, fail_c, tmo_c, tmr_load_c;

  assign hs_c       = s_valid_i && s_ready_o;
  assign active_c   = (state_q == ST_WR) || (state_q == ST_UPD);
  // An error response beats a simultaneous ack; timeout only if nothing came back.
  assign ack_ok_c   = active_c && wb_ack_i && !wb_err_i;
  assign fail_c     = active_c && (wb_err_i || (tmo_c && !wb_ack_i));
  assign tmr_load_c = (state_d != state_q) && ((state_d == ST_WR) || (state_d == ST_UPD));

  wb_write_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .load      (tmr_load_c),
    .run       (active_c),
    .expire_c  (tmo_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    last_d    = last_q;
    adr_d     = wb_adr_o;
    dat_d     = wb_dat_o;
    done_d    = 1'b0;
    err_d     = err_o && !err_clr_i;
    err_adr_d = err_adr_o;
    cnt_d     = wr_count_o;

    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          state_d = ST_WR;
          tgt_d   = s_target_i;
          last_d  = s_last_i;
          adr_d   = {s_target_i, s_addr_i, 2'b00};
          dat_d   = {14'b0, s_data_i};
        end
      end
      ST_WR, ST_UPD: begin
        if (fail_c) begin
          state_d   = last_q ? ST_IDLE : ST_DRAIN;
          err_d     = 1'b1;
          err_adr_d = wb_adr_o;
        end else if (ack_ok_c) begin
          cnt_d = wr_count_o + WR_CNT_W'(1);
          if (state_q == ST_WR) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (last_q && (AUTO_UPDATE != 0)) begin
          state_d = ST_UPD;
          adr_d   = {tgt_q, REG_UPDATE};
          dat_d   = WB_DAT_W'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = last_q;
        end
      end
      ST_DRAIN: begin
        if (hs_c && s_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cyc_d   = (state_d == ST_WR) || (state_d == ST_UPD);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
    busy_d  = (state_d != ST_IDLE);
    if (!cyc_d) begin
      adr_d = '0;
      dat_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      last_q     <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= 4'h0;
      s_ready_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_adr_o  <= '0;
      wr_count_o <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      last_q     <= last_d;
      wb_cyc_o   <= cyc_d;
      wb_stb_o   <= cyc_d;
      wb_we_o    <= cyc_d;
      wb_adr_o   <= adr_d;
      wb_dat_o   <= dat_d;
      wb_sel_o   <= cyc_d ? 4'hF : 4'h0;
      s_ready_o  <= ready_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_adr_o  <= err_adr_d;
      wr_count_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader with a small Wishbone slave model.
module tb_biquad8_coeff_loader;
  import biquad8_ctrl_pkg::*;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        s_valid_i, s_ready_o, s_last_i;
  logic [3:0]  s_target_i;
  logic [4:0]  s_addr_i;
  logic [17:0] s_data_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [10:0] wb_adr_o, err_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;
  logic        busy_o, done_o, err_o, err_clr_i;
  logic [15:0] wr_count_o;

  logic m_ack = 1'b0, m_err = 1'b0, stray_ack;
  assign wb_ack_i = m_ack | stray_ack;
  assign wb_err_i = m_err;

  int checks = 0, errors = 0;
  int rsp_delay = 1, wait_cnt = 0, m;
  int modes[$];
  logic [10:0] log_adr[$];
  logic [31:0] log_dat[$];
  int done_cnt = 0, rises = 0, run_len = 0, last_run = 0, viol = 0, strobe_bad = 0;
  logic cyc_prev = 1'b0;
  int c0, d0, r0;

  typedef struct {
    logic [3:0]  tgt;
    logic [4:0]  addr;
    logic [17:0] data;
    int          dly;
    logic [10:0] exp_adr;
    logic [31:0] exp_dat;
    logic [10:0] exp_upd;
  } vec_t;
  vec_t vecs[5];

  biquad8_coeff_loader #(
    .NTARGET(12), .TGTBITS(4), .TIMEOUT(15), .AUTO_UPDATE(1)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_target_i(s_target_i),
    .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_adr_o(err_adr_o),
    .err_clr_i(err_clr_i), .wr_count_o(wr_count_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave model: responds rsp_delay cycles into each write per the modes queue.
  always @(negedge wb_clk_i) begin
    m_ack = 1'b0;
    m_err = 1'b0;
    if (!wb_cyc_o) begin
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      if (wait_cnt == rsp_delay) begin
        m = (modes.size() != 0) ? modes[0] : M_ACK;
        if (m != M_NONE) begin
          if (modes.size() != 0) void'(modes.pop_front());
          m_ack = (m == M_ACK) || (m == M_BOTH);
          m_err = (m == M_ERR) || (m == M_BOTH);
          if (m == M_ACK) begin
            log_adr.push_back(wb_adr_o);
            log_dat.push_back(wb_dat_o);
            if (!(wb_stb_o && wb_we_o && wb_sel_o == 4'hF)) strobe_bad++;
          end
        end
      end
    end
  end

  // Bus monitor: done pulses, cyc rises, cyc-high run lengths, ready-while-writing.
  always @(negedge wb_clk_i) begin
    if (done_o) done_cnt++;
    if (wb_cyc_o && s_ready_o) viol++;
    if (wb_cyc_o) begin
      if (!cyc_prev) rises++;
      run_len++;
    end else if (cyc_prev) begin
      last_run = run_len;
      run_len  = 0;
    end
    cyc_prev = wb_cyc_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] t, input logic [4:0] a, input logic [17:0] d,
                           input logic l);
    int n = 0;
    @(negedge wb_clk_i);
    s_target_i = t; s_addr_i = a; s_data_i = d; s_last_i = l; s_valid_i = 1'b1;
    while (!s_ready_o && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("send_ready", s_ready_o, 1);
    @(negedge wb_clk_i);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge wb_clk_i);
    while (busy_o && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("wait_idle", busy_o, 0);
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic clear_err();
    @(negedge wb_clk_i);
    err_clr_i = 1'b1;
    @(negedge wb_clk_i);
    err_clr_i = 1'b0;
    chk("err_clr", err_o, 0);
  endtask

  task automatic start_pkt();
    c0 = int'(wr_count_o); d0 = done_cnt; r0 = rises;
    log_adr.delete(); log_dat.delete();
  endtask

  initial begin
    wb_rst_ni = 1'b0; s_valid_i = 1'b0; s_target_i = '0; s_addr_i = '0;
    s_data_i = '0; s_last_i = 1'b0; err_clr_i = 1'b0; stray_ack = 1'b0;

    vecs[0] = '{4'd3,  5'd1,  18'h2ABCD, 6,  11'h184, 32'h0002ABCD, 11'h180};
    vecs[1] = '{4'd0,  5'd2,  18'h3FFFF, 1,  11'h008, 32'h0003FFFF, 11'h000};
    vecs[2] = '{4'd15, 5'd31, 18'h00001, 3,  11'h7FC, 32'h00000001, 11'h780};
    vecs[3] = '{4'd13, 5'(REG_G_XLINK >> 2), 18'h12345, 10, 11'h69C, 32'h00012345, 11'h680};
    vecs[4] = '{4'd8,  5'd0,  18'h20000, 2,  11'h400, 32'h00020000, 11'h400};

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_count", wr_count_o, 0);
    wb_rst_ni = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    chk("idle_ready", s_ready_o, 1);
    chk("idle_busy", busy_o, 0);

    // Ack with cyc low is ignored
    stray_ack = 1'b1;
    @(negedge wb_clk_i);
    stray_ack = 1'b0;
    @(negedge wb_clk_i);
    chk("stray_ack_count", wr_count_o, 0);
    chk("stray_ack_cyc", wb_cyc_o, 0);

    // Single-beat packets: data write then update write
    for (int i = 0; i < 5; i++) begin
      start_pkt();
      rsp_delay = vecs[i].dly;
      send_beat(vecs[i].tgt, vecs[i].addr, vecs[i].data, 1'b1);
      wait_idle();
      chk($sformatf("v%0d_nwr", i), log_adr.size(), 2);
      if (log_adr.size() == 2) begin
        chk($sformatf("v%0d_adr", i), log_adr[0], vecs[i].exp_adr);
        chk($sformatf("v%0d_dat", i), log_dat[0], vecs[i].exp_dat);
        chk($sformatf("v%0d_upd_adr", i), log_adr[1], vecs[i].exp_upd);
        chk($sformatf("v%0d_upd_dat", i), log_dat[1], 32'h1);
      end
      chk($sformatf("v%0d_rises", i), rises - r0, 2);
      chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_count", i), wr_count_o, 16'(c0 + 2));
    end

    // Three-beat packet to target 0
    start_pkt();
    rsp_delay = 2;
    send_beat(4'd0, 5'(REG_FIR >> 2), 18'h11111, 1'b0);
    send_beat(4'd0, 5'(REG_IIR >> 2), 18'h22222, 1'b0);
    send_beat(4'd0, 5'(REG_F_CHAIN >> 2), 18'h33333, 1'b1);
    wait_idle();
    chk("p3_nwr", log_adr.size(), 4);
    if (log_adr.size() == 4) begin
      chk("p3_adr0", log_adr[0], 11'h004);
      chk("p3_adr1", log_adr[1], 11'h008);
      chk("p3_adr2", log_adr[2], 11'h010);
      chk("p3_adr3", log_adr[3], 11'h000);
      chk("p3_dat2", log_dat[2], 32'h00033333);
      chk("p3_dat3", log_dat[3], 32'h1);
    end
    chk("p3_rises", rises - r0, 4);
    chk("p3_done", done_cnt - d0, 1);
    chk("p3_count", wr_count_o, 16'(c0 + 4));
    chk("ready_while_busy", viol, 0);
    chk("strobes", strobe_bad, 0);

    // Timeout on first of three beats, then drain
    start_pkt();
    rsp_delay = 1;
    modes.push_back(M_NONE);
    send_beat(4'd5, 5'(REG_G_CHAIN >> 2), 18'h0AAAA, 1'b0);
    for (int n = 0; n < 100 && !err_o; n++) @(negedge wb_clk_i);
    chk("tmo_err", err_o, 1);
    @(negedge wb_clk_i);
    chk("tmo_cyc_len", last_run, 15);
    chk("tmo_err_adr", err_adr_o, 11'h294);
    chk("tmo_cyc_low", wb_cyc_o, 0);
    modes.delete();
    send_beat(4'd5, 5'(REG_F_XLINK >> 2), 18'h0BBBB, 1'b0);
    send_beat(4'd5, 5'd1, 18'h0CCCC, 1'b1);
    wait_idle();
    chk("tmo_rises", rises - r0, 1);
    chk("tmo_count", wr_count_o, 16'(c0));
    chk("tmo_done", done_cnt - d0, 0);
    chk("tmo_err_held", err_o, 1);
    clear_err();

    // Bus error on second of three beats
    start_pkt();
    rsp_delay = 3;
    modes.push_back(M_ACK);
    modes.push_back(M_ERR);
    send_beat(4'd7, 5'(REG_FIR >> 2), 18'h01234, 1'b0);
    send_beat(4'd7, 5'(REG_IIR >> 2), 18'h05678, 1'b0);
    send_beat(4'd7, 5'(REG_F_CHAIN >> 2), 18'h09ABC, 1'b1);
    wait_idle();
    chk("berr_count", wr_count_o, 16'(c0 + 1));
    chk("berr_err", err_o, 1);
    chk("berr_err_adr", err_adr_o, 11'h388);
    chk("berr_rises", rises - r0, 2);
    chk("berr_done", done_cnt - d0, 0);
    clear_err();

    // Error set and clear in the same cycle: set wins
    start_pkt();
    modes.delete();
    modes.push_back(M_ERR);
    rsp_delay = 3;
    err_clr_i = 1'b1;
    send_beat(4'd2, 5'd3, 18'h00042, 1'b1);
    for (int n = 0; n < 100 && wb_cyc_o; n++) @(negedge wb_clk_i);
    err_clr_i = 1'b0;
    chk("setwin_err", err_o, 1);
    @(negedge wb_clk_i);
    chk("setwin_err_hold", err_o, 1);
    chk("setwin_busy", busy_o, 0);
    chk("setwin_done", done_cnt - d0, 0);
    clear_err();

    // Ack and err together: error, not counted, no update write
    start_pkt();
    modes.delete();
    modes.push_back(M_BOTH);
    rsp_delay = 2;
    send_beat(4'd9, 5'd2, 18'h1ABCD, 1'b1);
    wait_idle();
    chk("both_count", wr_count_o, 16'(c0));
    chk("both_err", err_o, 1);
    chk("both_err_adr", err_adr_o, 11'h488);
    chk("both_rises", rises - r0, 1);
    chk("both_done", done_cnt - d0, 0);

    // Reset in the middle of a write
    modes.delete();
    modes.push_back(M_NONE);
    send_beat(4'd1, 5'd1, 18'h3C3C3, 1'b1);
    repeat (3) @(negedge wb_clk_i);
    chk("mid_cyc_before", wb_cyc_o, 1);
    wb_rst_ni = 1'b0;
    #1;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_we", wb_we_o, 0);
    chk("mid_rst_adr", wb_adr_o, 0);
    chk("mid_rst_dat", wb_dat_o, 0);
    chk("mid_rst_sel", wb_sel_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_err_adr", err_adr_o, 0);
    chk("mid_rst_count", wr_count_o, 0);
    modes.delete();
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    start_pkt();
    rsp_delay = 4;
    send_beat(4'd6, 5'd3, 18'h1F00F, 1'b1);
    wait_idle();
    chk("post_rst_nwr", log_adr.size(), 2);
    if (log_adr.size() == 2) begin
      chk("post_rst_adr", log_adr[0], 11'h30C);
      chk("post_rst_dat", log_dat[0], 32'h0001F00F);
      chk("post_rst_upd", log_adr[1], 11'h300);
    end
    chk("post_rst_count", wr_count_o, 16'd2);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
- Wishbone master that sequences coefficient loading into a bank of NTARGET biquad8 filter wrappers. Each wrapper sits in its own 128-byte window.
- Accepts a stream of coefficient beats and turns each beat into one Wishbone write.
- Waits for the slow cross-clock ack from the target wrapper.
- At end of packet, optionally issues the wrapper's update write so the new coefficients take effect atomically.
- Sits between the control CPU/command FIFO and the filter-bank Wishbone interconnect.

Parameters:
- NTARGET, 16, number of biquad8 wrappers addressed.
- TGTBITS, 4, target index width; must satisfy 2**TGTBITS >= NTARGET.
- TIMEOUT, 1023, wb_clk_i cycles to wait for ack before declaring an error.
- AUTO_UPDATE, 1, when 1, the last beat of a packet is followed by an update write.

Ports:
- wb_clk_i  in  1  clock, the Wishbone domain.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- s_valid_i  in  1  command beat valid.
- s_ready_o  out  1  command beat accepted when s_valid_i && s_ready_o.
- s_target_i  in  TGTBITS  target wrapper index.
- s_addr_i  in  5  register word index within the wrapper (byte addr = s_addr_i<<2).
- s_data_i  in  18  coefficient value.
- s_last_i  in  1  last beat of the packet.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master strobes.
- wb_adr_o  out  7+TGTBITS  {target, s_addr_i, 2'b00}.
- wb_dat_o  out  32  {14'b0, data}.
- wb_sel_o  out  4  always 4'hF during a write.
- wb_ack_i, wb_err_i  in  1 each  slave response.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a packet completes without error.
- err_o  out  1  sticky error flag.
- err_adr_o  out  7+TGTBITS  address of the failed write.
- err_clr_i  in  1  clears err_o.
- wr_count_o  out  16  count of acked writes; wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all wb_* outputs 0; s_ready_o=0; done_o=0; err_o=0; err_adr_o=0; wr_count_o=0.
- States: IDLE, WR, GAP, UPD, DRAIN.
- IDLE:
  - s_ready_o=1.
  - On handshake, register target/addr/data/last and go to WR.
  - wb_cyc_o/stb_o/we_o rise the cycle after the handshake (1-cycle latency).
- WR:
  - cyc/stb/we held constant until wb_ack_i, wb_err_i or timeout.
  - Timeout counter resets on WR/UPD entry; expiry occurs after TIMEOUT cycles without a response.
  - On ack: drop cyc/stb the next cycle, increment wr_count_o, go to GAP.
- GAP (one cycle, cyc=0, needed so the target's pending flag clears):
  - If the beat was last and AUTO_UPDATE=1, go to UPD.
  - If last and AUTO_UPDATE=0, pulse done_o and go to IDLE.
  - Otherwise go to IDLE.
- UPD:
  - Write to adr {target, 7'h00}, dat 32'h1, same ack/timeout rules as WR.
  - On ack: increment wr_count_o, pulse done_o, go to IDLE.
- Error (wb_err_i or timeout, in WR or UPD):
  - Drop cyc/stb next cycle.
  - Set err_o; latch err_adr_o.
  - Suppress done_o and any update.
  - If the failing beat was not last, go to DRAIN; otherwise go to IDLE.
- DRAIN: s_ready_o=1; accept and discard beats until a beat with s_last_i=1, then go to IDLE. No WB activity.
- Simultaneous ack and err: err wins; the write is not counted.
- err_clr_i: clears err_o in any state. If an error is being set in the same cycle, set wins.
- Ack while cyc is low: ignored.
- Target in range NTARGET..2**TGTBITS-1: still issued to the bus; the interconnect returns err or the write times out.

Decomposition:
- Package biquad8_ctrl_pkg:
  - state enum.
  - localparams for register offsets: UPDATE=7'h00, FIR=7'h04, IIR=7'h08, F_CHAIN=7'h10, G_CHAIN=7'h14, F_XLINK=7'h18, G_XLINK=7'h1C.
  - Default TIMEOUT.
- One sub-module, wb_write_timer: timeout down-counter with load/expire.

Test Plan:
- Single beat, target 3, addr 1, data 18'h2ABCD, last=1, AUTO_UPDATE=1, ack 6 cycles later -> wb_adr_o=11'h184, wb_dat_o=32'h0002ABCD; then GAP; then write adr 11'h180 dat 1; done_o pulses once; wr_count_o=2.
- 3-beat packet (FIR, IIR, F_CHAIN) to target 0 -> three writes, each separated by ≥1 cyc-low cycle, then the update write; s_ready_o=0 while busy.
- No ack, TIMEOUT=15 -> cyc drops on cycle 16; err_o=1; err_adr_o correct; the remaining 2 beats are accepted and discarded; no update write; done_o never pulses.
- wb_err_i on the second of 3 beats -> same draining behaviour; wr_count_o=1; err_clr_i clears err_o.
- ack and err in the same cycle -> treated as error; wr_count_o unchanged.
- wb_rst_ni low mid-WR -> all outputs 0 immediately; after release, a new packet completes normally.
